// File: rtl/flasher_pkg.sv
// Shared types, sizes and helpers for the bound-flasher sequencer.
package flasher_pkg;

  // LED bar width; the thermometer helper below is sized by it.
  localparam int unsigned WIDTH         = 16;
  localparam int unsigned NUM_SEG_DEF   = 8;
  localparam int unsigned CHECK_LVL_DEF = 6;

  // A level spans 0..WIDTH inclusive.
  localparam int unsigned LVL_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    FINISH
  } state_e;

  // One table entry: peak level, then trough level.
  typedef struct packed {
    logic [LVL_W-1:0] up;
    logic [LVL_W-1:0] down;
  } seg_t;

  // Levels above the bar width are stored as a full bar.
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
    return (lvl > LVL_W'(WIDTH)) ? LVL_W'(WIDTH) : lvl;
  endfunction

  // Thermometer code: the lowest lvl LEDs lit, (1 << lvl) - 1.
  function automatic logic [WIDTH-1:0] therm(input logic [LVL_W-1:0] lvl);
    logic [WIDTH-1:0] ones;
    ones = '1;
    return ~(ones << lvl);
  endfunction

endpackage

// File: rtl/flasher_seg_table.sv
// Segment table: NUM_SEG (up, down) level pairs, clamped on write,
// read combinationally by the running segment index.
module flasher_seg_table
  import flasher_pkg::*;
#(
  parameter  int unsigned NUM_SEG = NUM_SEG_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_SEG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [LVL_W-1:0] wr_up_i,
  input  logic [LVL_W-1:0] wr_down_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [LVL_W-1:0] rd_up_o,
  output logic [LVL_W-1:0] rd_down_o
);

  seg_t table_q [NUM_SEG];

  // Table write port with level clamping.
  // NOTE: this is a handful of flops rather than a RAM macro, so it can and
  // must take the reset; a sequence started right after reset sees zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      table_q <= '{default: '0};
    end else if (wr_en_i) begin
      table_q[wr_addr_i] <= '{up: clamp_lvl(wr_up_i), down: clamp_lvl(wr_down_i)};
    end
  end

  assign rd_up_o   = table_q[rd_idx_i].up;
  assign rd_down_o = table_q[rd_idx_i].down;

endmodule

// File: rtl/flasher_seq_ctrl.sv
// Bound-flasher sequencer: ramps a thermometer-coded LED bar up to each
// segment's peak and down to its trough, with flick restarts at checkpoints
// and a busy/done handshake toward the enclosing controller.
module flasher_seq_ctrl
  import flasher_pkg::*;
#(
  parameter  int unsigned NUM_SEG   = NUM_SEG_DEF,
  parameter  int unsigned CHECK_LVL = CHECK_LVL_DEF,
  localparam int unsigned IDX_W     = $clog2(NUM_SEG),
  localparam int unsigned CNT_W     = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [LVL_W-1:0] cfg_up,
  input  logic [LVL_W-1:0] cfg_down,
  input  logic [CNT_W-1:0] seg_count,
  input  logic             start,
  input  logic             flick,
  output logic [WIDTH-1:0] LED,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] seg_idx
);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LVL_W-1:0] cur_up, cur_down;
  logic [CNT_W-1:0] count_req;
  logic             go, accept, below_up, seg_done, last_seg, at_check;

  // The table only accepts writes while no sequence is running.
  flasher_seg_table #(.NUM_SEG(NUM_SEG)) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (cfg_we && (state_q == IDLE)),
    .wr_addr_i (cfg_addr),
    .wr_up_i   (cfg_up),
    .wr_down_i (cfg_down),
    .rd_idx_i  (seg_idx_q),
    .rd_up_o   (cur_up),
    .rd_down_o (cur_down)
  );

  // A flick in IDLE behaves like start; requests beyond the table depth run the whole table.
  assign count_req = (seg_count > CNT_W'(NUM_SEG)) ? CNT_W'(NUM_SEG) : seg_count;
  assign go        = start | flick;
  assign accept    = go && (count_req != '0);
  assign below_up  = lvl_q < cur_up;
  // Trough test also catches lvl == 0, so the down ramp never underflows.
  assign seg_done  = lvl_q <= cur_down;
  assign last_seg  = (CNT_W'(seg_idx_q) == count_q - CNT_W'(1));
  assign at_check  = flick && ((lvl_q == '0) || (lvl_q == LVL_W'(CHECK_LVL)));

  // State register plus the datapath and output registers.
  // NOTE: every flop here uses <= so all of them sample pre-edge values;
  // a blocking = would let later lines see this edge's updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      seg_idx_q <= '0;
      count_q   <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      seg_idx_q <= seg_idx_d;
      count_q   <= count_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state decode; flick in DOWN at a checkpoint outranks segment completion.
  always_comb begin
    // NOTE: defaulting first means every path assigns state_d, so no latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = UP;
      UP:      if (!below_up) state_d = DOWN;
      DOWN: begin
        if (at_check)      state_d = UP;
        else if (seg_done) state_d = last_seg ? FINISH : UP;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; LED and busy follow the values being loaded.
  always_comb begin
    lvl_d     = lvl_q;
    seg_idx_d = seg_idx_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          count_d   = count_req;
          seg_idx_d = '0;
          lvl_d     = '0;
        end else if (go) begin
          done_d = 1'b1;
        end
      end
      UP: begin
        if (below_up) lvl_d = lvl_q + LVL_W'(1);
      end
      DOWN: begin
        if (!at_check) begin
          if (seg_done) begin
            if (last_seg) begin
              lvl_d     = '0;
              seg_idx_d = '0;
              done_d    = 1'b1;
            end else begin
              seg_idx_d = seg_idx_q + IDX_W'(1);
            end
          end else begin
            lvl_d = lvl_q - LVL_W'(1);
          end
        end
      end
      FINISH: begin
        lvl_d     = '0;
        seg_idx_d = '0;
      end
      default: begin
        lvl_d     = '0;
        seg_idx_d = '0;
      end
    endcase
    led_d  = therm(lvl_d);
    busy_d = (state_d == UP) || (state_d == DOWN);
  end

  assign LED     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seg_idx = seg_idx_q;

endmodule

// File: tb/tb_flasher_seq_ctrl.sv
// Directed bench for flasher_seq_ctrl: per-cycle LED/seg_idx/busy/done traces
// against hand-built expected traces.
module tb_flasher_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [4:0]  cfg_up;
  logic [4:0]  cfg_down;
  logic [3:0]  seg_count;
  logic        start;
  logic        flick;
  logic [15:0] LED;
  logic        busy;
  logic        done;
  logic [2:0]  seg_idx;

  // {LED, seg_idx, busy, done}
  typedef logic [20:0] obs_t;
  obs_t obs_q[$];
  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  flasher_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_up    (cfg_up),
    .cfg_down  (cfg_down),
    .seg_count (seg_count),
    .start     (start),
    .flick     (flick),
    .LED       (LED),
    .busy      (busy),
    .done      (done),
    .seg_idx   (seg_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input int lvl, input int seg, input bit fin);
    logic [16:0] t;
    logic [2:0]  s;
    t = (17'd1 << lvl) - 17'd1;
    s = 3'(seg);
    exp_q.push_back({t[15:0], s, ~fin, fin});
  endfunction

  task automatic write_seg(input int addr, input int up, input int down);
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_up   = 5'(up);
    cfg_down = 5'(down);
    tick();
    cfg_we   = 1'b0;
  endtask

  // Launch a sequence and record one observation per edge until done or budget.
  // poke_at drives a start pulse and a table write on that edge (both should be dropped).
  task automatic run_seq(input int count, input bit via_flick, input int flick_a,
                         input int flick_b, input int poke_at, input int budget);
    obs_q.delete();
    tick();
    seg_count = 4'(count);
    if (via_flick) flick = 1'b1;
    else           start = 1'b1;
    tick();
    start = 1'b0;
    flick = 1'b0;
    obs_q.push_back({LED, seg_idx, busy, done});
    for (int n = 1; n <= budget; n++) begin
      if (done) break;
      flick = (n == flick_a) || (n == flick_b);
      if (n == poke_at) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_up   = 5'd2;
        cfg_down = 5'd1;
      end
      tick();
      flick  = 1'b0;
      start  = 1'b0;
      cfg_we = 1'b0;
      obs_q.push_back({LED, seg_idx, busy, done});
    end
    tick();
  endtask

  function automatic void build_two_seg();
    exp_q.delete();
    push_exp(0, 0, 0);
    for (int v = 1; v <= 11; v++) push_exp(v, 0, 0);
    push_exp(11, 0, 0);
    for (int v = 10; v >= 6; v--) push_exp(v, 0, 0);
    push_exp(6, 1, 0);
    push_exp(6, 1, 0);
    for (int v = 5; v >= 0; v--) push_exp(v, 1, 0);
    push_exp(0, 0, 1);
  endfunction

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    o = {LED, seg_idx, busy, done};
    checks++;
    if (o !== 21'h0) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", o, 21'h0);
    end
  endtask

  task automatic test_full_ramp();
    write_seg(0, 16, 0);
    exp_q.delete();
    push_exp(0, 0, 0);
    for (int v = 1; v <= 16; v++) push_exp(v, 0, 0);
    push_exp(16, 0, 0);
    for (int v = 15; v >= 0; v--) push_exp(v, 0, 0);
    push_exp(0, 0, 1);
    run_seq(1, 1'b0, -1, -1, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL full_ramp_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL full_ramp cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_ramp_done_pulse got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_two_segments();
    write_seg(0, 11, 6);
    write_seg(1, 6, 0);
    build_two_seg();
    run_seq(2, 1'b0, -1, -1, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL two_seg_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL two_seg cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_flick();
    // Flick at lvl 6 in seg1 DOWN (edge 20) reverses; flick at lvl 5 (edge 23) does nothing.
    exp_q.delete();
    push_exp(0, 0, 0);
    for (int v = 1; v <= 11; v++) push_exp(v, 0, 0);
    push_exp(11, 0, 0);
    for (int v = 10; v >= 6; v--) push_exp(v, 0, 0);
    for (int k = 0; k < 4; k++) push_exp(6, 1, 0);
    for (int v = 5; v >= 0; v--) push_exp(v, 1, 0);
    push_exp(0, 0, 1);
    run_seq(2, 1'b0, 20, 23, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL flick_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL flick cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    build_two_seg();
    run_seq(2, 1'b0, -1, -1, 5, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL busy_ignore_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    // Rerun: identical trace shows entry 0 kept (11, 6).
    run_seq(2, 1'b0, -1, -1, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL table_kept_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL table_kept cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    write_seg(0, 16, 0);
    seg_count = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (LED !== 16'h01FF || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got led=%h busy=%b expected 01ff 1", LED, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    o = {LED, seg_idx, busy, done};
    checks++;
    if (o !== 21'h0) begin
      errors++;
      $display("FAIL abort_edge got %h expected %h", o, 21'h0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      o = {LED, seg_idx, busy, done};
      checks++;
      if (o !== 21'h0) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d got %h expected %h", k, o, 21'h0);
      end
    end
    // All-zero table: every segment is one UP edge plus one DOWN edge at lvl 0.
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      push_exp(0, k, 0);
      push_exp(0, k, 0);
    end
    push_exp(0, 0, 1);
    run_seq(8, 1'b0, -1, -1, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL zero_table_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL zero_table cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    seg_count = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || LED !== 16'h0) begin
      errors++;
      $display("FAIL zero_count_pulse got done=%b busy=%b led=%h expected 1 0 0000", done, busy, LED);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || LED !== 16'h0) begin
      errors++;
      $display("FAIL zero_count_after got done=%b busy=%b led=%h expected 0 0 0000", done, busy, LED);
    end
    // seg_count 12 must run exactly the 8 table entries.
    for (int k = 0; k < 8; k++) write_seg(k, 1, 0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      push_exp(0, k, 0);
      push_exp(1, k, 0);
      push_exp(1, k, 0);
      push_exp(0, k, 0);
    end
    push_exp(0, 0, 1);
    run_seq(12, 1'b0, -1, -1, -1, 80);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL count_clamp_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL count_clamp cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    // Flick starts from IDLE; (25, 20) stores as (16, 16).
    write_seg(0, 25, 20);
    exp_q.delete();
    push_exp(0, 0, 0);
    for (int v = 1; v <= 16; v++) push_exp(v, 0, 0);
    push_exp(16, 0, 0);
    push_exp(0, 0, 1);
    run_seq(1, 1'b1, -1, -1, -1, 60);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lvl_clamp_len got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL lvl_clamp cycle %0d got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_up    = 5'd0;
    cfg_down  = 5'd0;
    seg_count = 4'd0;
    start     = 1'b0;
    flick     = 1'b0;
    test_reset();
    test_full_ramp();
    test_two_segments();
    test_flick();
    test_busy_ignore();
    test_reset_abort();
    test_zero_and_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
